// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, colours and arbiter state encoding
package vga_pkg;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 9;
  localparam int XMAX = 160;
  localparam int YMAX = 120;

  localparam logic [CW-1:0] BLACK       = 9'h000;
  localparam logic [CW-1:0] SNAKE_GREEN = 9'h038;
  localparam logic [CW-1:0] FOOD_RED    = 9'h1C0;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first valid at or after the pointer
module rr_picker #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx
);
  always_comb begin
    int w_j;
    w_j     = 0;
    o_grant = '0;
    o_idx   = '0;
    // Scan from farthest to nearest so the nearest valid requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (i_valid[w_j]) begin
        o_grant      = '0;
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
      end
    end
  end
endmodule

// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - shares the VGA pixel-write port between drawers and a clear sweeper
module vga_write_arbiter
  import vga_pkg::*;
#(
  parameter int            NREQ           = 3,
  parameter logic [CW-1:0] CLEAR_COLOUR   = BLACK,
  parameter bit            CLEAR_ON_RESET = 1'b1,
  localparam int           GW             = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               clear_start,
  output logic               clear_busy,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*XW-1:0] req_x,
  input  logic [NREQ*YW-1:0] req_y,
  input  logic [NREQ*CW-1:0] req_colour,
  output logic               plot,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [CW-1:0]      colour,
  output logic [GW-1:0]      grant_id
);
  state_t          r_state;
  state_t          w_state_next;
  logic            r_boot;
  logic [GW-1:0]   r_ptr;
  logic [XW-1:0]   r_sx;
  logic [YW-1:0]   r_sy;
  logic            r_plot;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [CW-1:0]   r_colour;
  logic [GW-1:0]   r_grant;

  logic [NREQ-1:0] w_grant;
  logic [GW-1:0]   w_idx;
  logic            w_go_clear;
  logic            w_last;
  logic            w_xfer;
  logic            w_sweep;

  rr_picker #(.NREQ(NREQ), .IW(GW)) u_picker (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // A pending power-on clear blocks service exactly like a clear_start pulse.
  assign w_go_clear = (r_state == SERVE) && (clear_start || r_boot);
  assign w_last     = (r_state == CLEAR) && (r_x == XW'(XMAX - 1)) && (r_y == YW'(YMAX - 1));
  assign req_ready  = ((r_state == SERVE) && !w_go_clear) ? w_grant : '0;
  assign w_xfer     = |req_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SERVE:   if (w_go_clear) w_state_next = CLEAR;
      CLEAR:   if (w_last)     w_state_next = SERVE;
      default: w_state_next = SERVE;
    endcase
  end

  // The sweeper issues a pixel on every edge that lands in CLEAR, so plot and clear_busy align.
  assign w_sweep = (w_state_next == CLEAR);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= SERVE;
      r_boot   <= CLEAR_ON_RESET;
      r_ptr    <= '0;
      r_sx     <= '0;
      r_sy     <= '0;
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_grant  <= '0;
    end else begin
      r_state <= w_state_next;
      r_plot  <= w_sweep | w_xfer;
      if (w_go_clear) r_boot <= 1'b0;
      if (w_sweep) begin
        r_x      <= r_sx;
        r_y      <= r_sy;
        r_colour <= CLEAR_COLOUR;
        if (r_sx == XW'(XMAX - 1)) begin
          r_sx <= '0;
          r_sy <= (r_sy == YW'(YMAX - 1)) ? '0 : r_sy + YW'(1);
        end else begin
          r_sx <= r_sx + XW'(1);
        end
      end else if (w_xfer) begin
        r_x      <= req_x[int'(w_idx)*XW +: XW];
        r_y      <= req_y[int'(w_idx)*YW +: YW];
        r_colour <= req_colour[int'(w_idx)*CW +: CW];
        r_grant  <= w_idx;
        r_ptr    <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + GW'(1);
      end
    end
  end

  assign clear_busy = (r_state == CLEAR);
  assign plot       = r_plot;
  assign x          = r_x;
  assign y          = r_y;
  assign colour     = r_colour;
  assign grant_id   = r_grant;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb/tb_vga_write_arbiter.sv - randomized and directed bench for vga_write_arbiter
module tb_vga_write_arbiter;
  import vga_pkg::*;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic [2:0]    req_valid = '0;
  logic [2:0]    req_ready;
  logic [23:0]   req_x = '0;
  logic [20:0]   req_y = '0;
  logic [26:0]   req_colour = '0;
  logic          plot;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [8:0]    colour;
  logic [1:0]    grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] v_x[3];
  logic [6:0] v_y[3];
  logic [8:0] v_c[3];
  bit         hold[3];
  logic [2:0] v_valid;

  int         m_ptr;
  logic       m_plot;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [8:0] m_c;
  logic [1:0] m_g;
  int         order[6];

  vga_write_arbiter dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .grant_id   (grant_id)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive();
    req_valid  = v_valid;
    req_x      = {v_x[2], v_x[1], v_x[0]};
    req_y      = {v_y[2], v_y[1], v_y[0]};
    req_colour = {v_c[2], v_c[1], v_c[0]};
  endtask

  task automatic model_reset();
    m_ptr = 0; m_plot = 0; m_x = '0; m_y = '0; m_c = '0; m_g = '0;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    v_valid = '0;
  endtask

  task automatic model_after_sweep();
    m_plot = 1'b0;
    m_x = 8'(XMAX - 1);
    m_y = 7'(YMAX - 1);
    m_c = BLACK;
  endtask

  // One serving cycle: check registered outputs, present requests, check ready, advance the model.
  task automatic cyc(input logic [2:0] force_mask, input bit rnd);
    int j;
    logic [2:0] exp_ready;
    chk("serve_out", {plot, x, y, colour, grant_id}, {m_plot, m_x, m_y, m_c, m_g});
    for (int i = 0; i < 3; i++) begin
      if (hold[i]) begin
        v_valid[i] = 1'b1;
      end else if (force_mask[i] || (rnd && $urandom_range(0, 1) == 1)) begin
        v_valid[i] = 1'b1;
        v_x[i] = 8'($urandom_range(0, 255));
        v_y[i] = 7'($urandom_range(0, 127));
        v_c[i] = 9'($urandom_range(0, 511));
      end else begin
        v_valid[i] = 1'b0;
      end
    end
    drive();
    #1;
    j = -1;
    for (int k = 0; k < 3; k++)
      if (j < 0 && v_valid[(m_ptr + k) % 3]) j = (m_ptr + k) % 3;
    exp_ready = (j < 0) ? 3'b000 : 3'(1 << j);
    chk("ready", req_ready, exp_ready);
    if (j >= 0) begin
      m_plot = 1'b1; m_x = v_x[j]; m_y = v_y[j]; m_c = v_c[j]; m_g = 2'(j);
      m_ptr = (j + 1) % 3;
    end else begin
      m_plot = 1'b0;
    end
    for (int i = 0; i < 3; i++) hold[i] = v_valid[i] && (i != j);
    tick();
  endtask

  task automatic sweep(input int from, input int upto, input int pulse_at);
    for (int p = from; p < upto; p++) begin
      clear_start = (p == pulse_at);
      chk("sweep", {plot, clear_busy, req_ready, x, y, colour},
          {1'b1, 1'b1, 3'b000, 8'(p % XMAX), 7'(p / XMAX), BLACK});
      tick();
    end
    clear_start = 1'b0;
  endtask

  initial begin
    order = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 3; i++) begin v_x[i] = '0; v_y[i] = '0; v_c[i] = '0; end
    model_reset();

    // Power-on reset with requests pending: nothing may be accepted.
    #5 reset = 1'b1;
    v_valid = 3'b111; drive();
    #19;
    chk("reset_vals", {plot, x, y, colour, grant_id, clear_busy, req_ready}, '0);
    v_valid = 3'b000; drive();
    #1 reset = 1'b0;
    tick();
    sweep(0, XMAX * YMAX, -1);
    chk("boot_clear_end", {plot, clear_busy}, 2'b00);
    model_after_sweep();

    // Single requester 1.
    v_x[1] = 8'd10; v_y[1] = 7'd20; v_c[1] = SNAKE_GREEN; hold[1] = 1;
    cyc(3'b000, 0);
    chk("single_plot", {plot, x, y, colour, grant_id}, {1'b1, 8'd10, 7'd20, SNAKE_GREEN, 2'd1});
    cyc(3'b000, 0);
    chk("single_idle", {plot, x, y}, {1'b0, 8'd10, 7'd20});

    // Requester 2 alone moves the pointer back to 0.
    v_x[2] = 8'd200; v_y[2] = 7'd127; v_c[2] = FOOD_RED; hold[2] = 1;
    cyc(3'b000, 0);
    cyc(3'b000, 0);

    // All three held valid: strict rotation, no gaps.
    cyc(3'b111, 0);
    for (int n = 0; n < 6; n++) begin
      chk("rr_order", {plot, grant_id}, {1'b1, 2'(order[n])});
      cyc((n < 5) ? 3'b111 : 3'b000, 0);
    end

    // clear_start with req 0 and 2 waiting, then a re-pulse mid-sweep.
    chk("serve_out", {plot, x, y, colour, grant_id}, {m_plot, m_x, m_y, m_c, m_g});
    for (int i = 0; i < 3; i += 2) begin
      v_x[i] = 8'($urandom_range(0, 255));
      v_y[i] = 7'($urandom_range(0, 127));
      v_c[i] = 9'($urandom_range(1, 511));
      hold[i] = 1;
    end
    v_valid = 3'b101; drive();
    clear_start = 1'b1;
    #1;
    chk("clear_req_ready", req_ready, 3'b000);
    tick();
    sweep(0, XMAX * YMAX, 5000);
    chk("repulse_clear_end", {plot, clear_busy}, 2'b00);
    model_after_sweep();
    cyc(3'b000, 0);
    cyc(3'b000, 0);
    cyc(3'b000, 0);

    // Reset in the middle of a sweep.
    clear_start = 1'b1;
    tick();
    sweep(0, 8000, -1);
    reset = 1'b1;
    #1;
    chk("reset_async", {plot, x, y, colour, grant_id, clear_busy}, '0);
    model_reset(); drive();
    @(posedge CLOCK_50);
    #5 reset = 1'b0;
    tick();
    sweep(0, XMAX * YMAX, -1);
    chk("restart_clear_end", {plot, clear_busy}, 2'b00);
    model_after_sweep();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) cyc(3'b000, 1);
    for (int n = 0; n < 4; n++) cyc(3'b000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
